sync_mod_counter: RTL and testbench
===================================

# sync_mod_counter

Parametrised synchronous modulo-N counter. It generalises the team's fixed-width, fixed-sequence synchronous counter into a reusable block with these features:
- configurable width and modulus
- up/down direction
- parallel load
- count enable with cascade terminal-count output
- free-running or one-shot mode

It sits in the lab datapath wherever a divider, sequencer step counter or cascaded timer is needed.

## Interface
- WIDTH, 3: counter width in bits; legal range 1 to 16.
- MODULUS, 6: number of states. Counts 0 to MODULUS-1. Legal range 2 to 2^WIDTH.
- clk  input  1  rising-edge clock; the only clock.
- clear  input  1  asynchronous, active-low reset.
- en  input  1  count enable; ANDed with the cascade input by the integrator.
- up  input  1  direction: 1 counts up, 0 counts down.
- oneshot  input  1  mode: 0 free-running wrap, 1 stop at the terminal value.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count, combinational: en & ~done & (up ? q==MODULUS-1 : q==0).
- done  output  1  registered; high while halted in one-shot mode.

## Operation
- State machine has two states: RUN and HALT. The `done` output is 1 exactly in HALT.
- Reset (clear=0): q=0, state=RUN, done=0. Reset acts immediately, independent of clk, and can occur mid-count.
- Per-edge priority is load > count > hold.
- load=1, any state:
  - q <= din, state <= RUN.
  - If din >= MODULUS, q <= MODULUS-1 (clamped).
  - en is ignored that cycle.
- RUN, en=1, up=1:
  - q <= q+1 if q < MODULUS-1.
  - At q=MODULUS-1: if oneshot=0, q <= 0 (wrap); if oneshot=1, q holds and state <= HALT.
- RUN, en=1, up=0:
  - q <= q-1 if q > 0.
  - At q=0: if oneshot=0, q <= MODULUS-1; if oneshot=1, q holds and state <= HALT.
- RUN, en=0: hold.
- HALT: q holds regardless of en, up and oneshot. Only load or clear exits HALT.
- Clearing oneshot while in HALT does not resume counting.
- Direction changes take effect on the next enabled edge, with no extra latency.
- Arithmetic is modulo MODULUS only. No intermediate value outside 0 to MODULUS-1 is ever registered.
- When MODULUS=2^WIDTH, the wrap is the natural overflow and the result must be identical.

## Timing
- q and done: one-cycle latency from the enabling edge.
- tc: zero latency; combinational from q, done, en and up.
  - tc is high in the cycle before the wrap edge or halt edge, so a downstream counter can use it as its en.
- Cascade rule: high-stage en = low-stage tc. The high stage steps on the same edge the low stage wraps.
- In one-shot mode, tc pulses for exactly one enabled cycle; done rises on the following edge.
- clear deassertion is not synchronised inside the block; the reset synchroniser lives at top level.

## Configuration
- Macro: SYNC_CNT_GRAY_EN.
- Defined: adds output port q_gray (WIDTH bits).
  - q_gray is registered and always equals binary-to-Gray of q in the same cycle: it is computed from the next value, not delayed.
  - Reset value is 0.
  - Gray adjacency holds only when MODULUS=2^WIDTH; otherwise the wrap step may change several bits, and this is documented behaviour.
- Undefined: the q_gray port and its register do not exist; all other behaviour is identical.

## Structure
- Shared package sync_cnt_pkg holds:
  - the state enum (RUN, HALT)
  - a function next_count(q, up, modulus)
  - a function bin2gray(value)
- Sub-module sync_cnt_core holds the q/state registers and next-state logic.
- The top level adds the tc decode, the parameter legality checks (elaboration-time) and the optional Gray register.

## Test plan
- Reset and free-run up:
  - WIDTH=3, MODULUS=6, en=1, up=1, oneshot=0 from clear.
  - Required: q = 0,1,2,3,4,5,0,1.
  - tc=1 only while q=5.
- Down wrap:
  - load din=0, then en=1, up=0.
  - Required: q = 0,5,4,3.
  - tc=1 while q=0.
- One-shot and clamp:
  - load din=7 (clamped to 5), oneshot=1, up=1.
  - Required: q=5; tc pulses 1 cycle; done=1 next edge; q stays 5 for 10 further enabled cycles.
  - Then load din=2: done=0, q=2.
- Cascade:
  - Two instances, MODULUS=6 low and MODULUS=4 high, high en = low tc.
  - After 24 enabled cycles from reset, both read 0.
  - High stage steps only on low-stage wrap edges.
- Async clear mid-count:
  - Assert clear=0 between edges while q=4.
  - Required: q=0 and done=0 immediately; counting resumes from 0 on the first edge after release.
- With SYNC_CNT_GRAY_EN, WIDTH=3, MODULUS=8:
  - Free-run through 16 cycles.
  - Required: q_gray == q ^ (q>>1) every cycle.
  - Exactly one bit changes per step, including the 7→0 wrap.

Source files
------------

// File: rtl/sync_cnt_pkg.sv
// Shared types and helpers for the modulo-N counter family.
// Next-count and Gray helpers work on 32-bit values; callers narrow to their own width.
package sync_cnt_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } cnt_state_e;

  function automatic logic [31:0] next_count(input logic [31:0] q,
                                             input logic        up,
                                             input logic [31:0] modulus);
    if (up) return (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
    else    return (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/sync_cnt_core.sv
// Count register and RUN/HALT state for sync_mod_counter.
// With SYNC_CNT_GRAY_EN defined, the next count is exported for the parent's Gray register.
//
// state | meaning
// RUN   | counting (or holding while en=0)
// HALT  | one-shot reached its terminal value; only load or clear leaves
module sync_cnt_core
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef SYNC_CNT_GRAY_EN
  output logic [WIDTH-1:0] q_next,
`endif
  output logic [WIDTH-1:0] q,
  output logic             done
);

  localparam logic [WIDTH-1:0] LP_Q_MAX = WIDTH'(MODULUS - 1);

  cnt_state_e       r_state;
  cnt_state_e       w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_at_term;

  assign w_at_term = up ? (r_q == LP_Q_MAX) : (r_q == '0);

  always_comb begin
    w_q_next     = r_q;
    w_state_next = r_state;
    if (load) begin
      // Out-of-range loads saturate so q never leaves 0..MODULUS-1.
      w_q_next     = (32'(din) >= 32'(MODULUS)) ? LP_Q_MAX : din;
      w_state_next = RUN;
    end else if (r_state == RUN && en) begin
      if (w_at_term && oneshot) w_state_next = HALT;
      else w_q_next = WIDTH'(next_count(32'(r_q), up, 32'(MODULUS)));
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_q     <= '0;
      r_state <= RUN;
    end else begin
      r_q     <= w_q_next;
      r_state <= w_state_next;
    end
  end

  assign q    = r_q;
  assign done = (r_state == HALT);
`ifdef SYNC_CNT_GRAY_EN
  assign q_next = w_q_next;
`endif

endmodule

// File: rtl/sync_mod_counter.sv
// Parametrised modulo-N up/down counter with load, one-shot mode and cascade tc.
// Optional feature macro SYNC_CNT_GRAY_EN adds a registered Gray-coded copy q_gray.
module sync_mod_counter
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
`ifdef SYNC_CNT_GRAY_EN
  output logic [WIDTH-1:0] q_gray,
`endif
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] LP_Q_MAX = WIDTH'(MODULUS - 1);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("sync_mod_counter: WIDTH %0d outside 1..16", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("sync_mod_counter: MODULUS %0d outside 2..2^WIDTH", MODULUS);
  end

  logic [WIDTH-1:0] w_q;
  logic             w_done;

`ifdef SYNC_CNT_GRAY_EN
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] r_q_gray;
`endif

  sync_cnt_core #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_core (
    .clk     (clk),
    .clear   (clear),
    .en      (en),
    .up      (up),
    .oneshot (oneshot),
    .load    (load),
    .din     (din),
`ifdef SYNC_CNT_GRAY_EN
    .q_next  (w_q_next),
`endif
    .q       (w_q),
    .done    (w_done)
  );

  assign q    = w_q;
  assign done = w_done;
  // Combinational so the next stage can step on the same edge this one wraps.
  assign tc   = en & ~w_done & (up ? (w_q == LP_Q_MAX) : (w_q == '0));

`ifdef SYNC_CNT_GRAY_EN
  // Encoded from the next count so q_gray tracks q without a cycle of lag.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) r_q_gray <= '0;
    else        r_q_gray <= WIDTH'(bin2gray(32'(w_q_next)));
  end
  assign q_gray = r_q_gray;
`endif

endmodule

// File: tb/tb_sync_mod_counter.sv
// Randomised and directed check of sync_mod_counter against an arithmetic reference model.
module tb_sync_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, en, up, oneshot, load;
  logic [2:0] din;
  logic [2:0] q6, q8;
  logic       tc6, tc8, done6, done8;

  logic       clear_c, en_c, c_up, c_os, c_load;
  logic [2:0] c_din_lo;
  logic [1:0] c_din_hi;
  logic [2:0] q_lo;
  logic [1:0] q_hi;
  logic       tc_lo, tc_hi, done_lo, done_hi;

`ifdef SYNC_CNT_GRAY_EN
  logic [2:0] g6, g8, g_lo;
  logic [1:0] g_hi;
`endif

  sync_mod_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
    .clk(clk), .clear(clear), .en(en), .up(up), .oneshot(oneshot), .load(load), .din(din),
    .q(q6),
`ifdef SYNC_CNT_GRAY_EN
    .q_gray(g6),
`endif
    .tc(tc6), .done(done6));

  sync_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .clear(clear), .en(en), .up(up), .oneshot(oneshot), .load(load), .din(din),
    .q(q8),
`ifdef SYNC_CNT_GRAY_EN
    .q_gray(g8),
`endif
    .tc(tc8), .done(done8));

  sync_mod_counter #(.WIDTH(3), .MODULUS(6)) dut_lo (
    .clk(clk), .clear(clear_c), .en(en_c), .up(c_up), .oneshot(c_os), .load(c_load),
    .din(c_din_lo), .q(q_lo),
`ifdef SYNC_CNT_GRAY_EN
    .q_gray(g_lo),
`endif
    .tc(tc_lo), .done(done_lo));

  sync_mod_counter #(.WIDTH(2), .MODULUS(4)) dut_hi (
    .clk(clk), .clear(clear_c), .en(tc_lo), .up(c_up), .oneshot(c_os), .load(c_load),
    .din(c_din_hi), .q(q_hi),
`ifdef SYNC_CNT_GRAY_EN
    .q_gray(g_hi),
`endif
    .tc(tc_hi), .done(done_hi));

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: index 0 is the MODULUS=6 counter, index 1 the MODULUS=8 counter.
  int mm[2] = '{6, 8};
  int mq[2];
  bit mh[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit at_term(int i);
    return up ? (mq[i] == mm[i] - 1) : (mq[i] == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0;
      mh[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (load) begin
        mq[i] = (int'(din) >= mm[i]) ? mm[i] - 1 : int'(din);
        mh[i] = 1'b0;
      end else if (!mh[i] && en) begin
        if (at_term(i) && oneshot) mh[i] = 1'b1;
        else mq[i] = up ? (mq[i] + 1) % mm[i] : (mq[i] + mm[i] - 1) % mm[i];
      end
    end
  endtask

  task automatic check_outputs();
    chk("q6", 32'(q6), 32'(mq[0]));
    chk("done6", 32'(done6), 32'(mh[0]));
    chk("q8", 32'(q8), 32'(mq[1]));
    chk("done8", 32'(done8), 32'(mh[1]));
`ifdef SYNC_CNT_GRAY_EN
    chk("gray6", 32'(g6), 32'(mq[0] ^ (mq[0] >> 1)));
    chk("gray8", 32'(g8), 32'(mq[1] ^ (mq[1] >> 1)));
`endif
  endtask

  // Inputs already set; check tc, then advance one edge and check registered outputs.
  task automatic cyc();
    #1;
    chk("tc6", 32'(tc6), 32'(en && !mh[0] && at_term(0)));
    chk("tc8", 32'(tc8), 32'(en && !mh[1] && at_term(1)));
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    clear = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0; load = 1'b0; din = '0;
    clear_c = 1'b0; en_c = 1'b0; c_up = 1'b1; c_os = 1'b0; c_load = 1'b0;
    c_din_lo = '0; c_din_hi = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    clear = 1'b1;

    // Free-run up from reset: 0,1,2,3,4,5,0,1
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk("freerun_end", 32'(q6), 32'd1);

    // Down wrap from 0: 5,4,3
    load = 1'b1; din = 3'd0; cyc();
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("down_end", 32'(q6), 32'd3);

    // One-shot with clamped load
    load = 1'b1; din = 3'd7; up = 1'b1; oneshot = 1'b1; cyc();
    chk("clamp", 32'(q6), 32'd5);
    load = 1'b0;
    #1 chk("os_tc_pulse", 32'(tc6), 32'd1);
    cyc();
    chk("os_done", 32'(done6), 32'd1);
    oneshot = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("os_hold", 32'(q6), 32'd5);
    load = 1'b1; din = 3'd2; cyc();
    chk("os_reload", 32'(q6), 32'd2);
    load = 1'b0;

    // Async clear mid-count at q=4
    load = 1'b1; din = 3'd4; cyc();
    load = 1'b0; en = 1'b0; up = 1'b1;
    #2 clear = 1'b0;
    #1;
    model_reset();
    chk("aclr_q", 32'(q6), 32'd0);
    chk("aclr_done", 32'(done6), 32'd0);
    #2 clear = 1'b1;
    en = 1'b1; cyc();
    chk("aclr_resume", 32'(q6), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      en      = ($urandom % 4) != 0;
      up      = $urandom % 2;
      oneshot = ($urandom % 3) == 0;
      load    = ($urandom % 8) == 0;
      din     = 3'($urandom % 8);
      if (($urandom % 60) == 0) begin
        #2 clear = 1'b0;
        #1 model_reset();
        check_outputs();
        #1 clear = 1'b1;
      end
      cyc();
    end

`ifdef SYNC_CNT_GRAY_EN
    // Natural-overflow Gray adjacency on the MODULUS=8 counter
    load = 1'b1; din = 3'd0; en = 1'b1; up = 1'b1; oneshot = 1'b0; cyc();
    load = 1'b0;
    for (int n = 0; n < 16; n++) begin
      logic [2:0] prev;
      prev = g8;
      cyc();
      chk("gray_adj", 32'($countones(prev ^ g8)), 32'd1);
    end
`endif

    // Cascade: MODULUS 6 low stage feeding MODULUS 4 high stage
    @(negedge clk);
    clear_c = 1'b1; en_c = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      #1 chk("casc_tc", 32'(tc_lo), 32'(((n - 1) % 6) == 5));
      @(posedge clk);
      #1;
      chk("casc_lo", 32'(q_lo), 32'(n % 6));
      chk("casc_hi", 32'(q_hi), 32'((n / 6) % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
